// File: rtl/acc_dump_scale.sv
// Integrate-and-dump sequencer and output scaler for the MRFM sample accumulator.
// Define DUMP_SATURATE_EN to saturate the narrowed dump (and flag overflow); otherwise it wraps.
module acc_dump_scale #(
    parameter int SUM_W = 50,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic [CNT_W-1:0]        length,
    input  logic [5:0]              shift,
    input  logic                    stb_in,
    input  logic                    acc_valid,
    input  logic signed [SUM_W-1:0] sum_in,
    output logic                    clear_out,
    output logic                    dump_strobe,
    output logic signed [OUT_W-1:0] dump_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam logic [5:0]       SH_MAX  = 6'(SUM_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        len_r;
    logic [CNT_W-1:0]        len_eff_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [5:0]              sh_r;
    logic [5:0]              sh_eff_s;
    logic [5:0]              sh1_r;
    logic                    tag_r;
    logic                    last_s;
    logic                    v1_r;
    logic                    v2_r;
    logic signed [SUM_W-1:0] cap_r;
    logic signed [SUM_W:0]   ext_s;
    logic signed [SUM_W:0]   half_s;
    logic signed [SUM_W:0]   rnd_s;
    logic signed [SUM_W:0]   r_r;
    logic                    sat_s;
    logic signed [OUT_W-1:0] narrow_s;

    // Period settings come from the ports only at a period start; otherwise the latched copies hold.
    always_comb begin
        len_eff_s = len_r;
        sh_eff_s  = sh_r;
        if (cnt_r == '0) begin
            len_eff_s = (length == '0) ? CNT_ONE : length;
            sh_eff_s  = (shift > SH_MAX) ? SH_MAX : shift;
        end else begin
            len_eff_s = len_r;
            sh_eff_s  = sh_r;
        end
        cnt_inc_s = cnt_r + CNT_ONE;
        last_s    = (cnt_inc_s == len_eff_s);
        clear_out = stb_in & run & (cnt_r == '0);
        busy      = (cnt_r != '0) | tag_r | v1_r | v2_r;
    end

    // Sample counter and last-sample tag (tag lines up with the accumulator's acc_valid).
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= '0;
            len_r <= CNT_ONE;
            sh_r  <= 6'd0;
            tag_r <= 1'b0;
        end else if (!run) begin
            cnt_r <= '0;
            tag_r <= 1'b0;
        end else if (stb_in) begin
            cnt_r <= last_s ? '0 : cnt_inc_s;
            len_r <= len_eff_s;
            sh_r  <= sh_eff_s;
            tag_r <= last_s;
        end else begin
            tag_r <= 1'b0;
        end
    end

    // Half-LSB rounding constant; the shift travels with the captured total so a new period cannot alter it.
    always_comb begin
        ext_s  = {cap_r[SUM_W-1], cap_r};
        half_s = '0;
        if (sh1_r != 6'd0) begin
            half_s[sh1_r - 6'd1] = 1'b1;
        end else begin
            half_s = '0;
        end
        rnd_s = ext_s + half_s;
    end

    // Capture and round/shift stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_r <= '0;
            sh1_r <= 6'd0;
            v1_r  <= 1'b0;
            r_r   <= '0;
            v2_r  <= 1'b0;
        end else begin
            if (acc_valid & tag_r) begin
                cap_r <= sum_in;
                sh1_r <= sh_r;
            end
            v1_r <= acc_valid & tag_r;
            r_r  <= rnd_s >>> sh1_r;
            v2_r <= v1_r;
        end
    end

`ifdef DUMP_SATURATE_EN
    function automatic logic [OUT_W:0] sat_narrow(input logic signed [SUM_W:0] v);
        logic [SUM_W-OUT_W+1:0] upper;
        upper = v[SUM_W:OUT_W-1];
        if ((upper == '0) || (upper == '1)) begin
            sat_narrow = {1'b0, v[OUT_W-1:0]};
        end else if (v[SUM_W]) begin
            sat_narrow = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_narrow = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    // Saturating narrow with a flag for the overflow register.
    always_comb begin
        {sat_s, narrow_s} = sat_narrow(r_r);
    end
`else
    logic unused_s;
    assign unused_s = ^r_r[SUM_W:OUT_W];

    // Two's-complement wrap; saturation never occurs.
    always_comb begin
        sat_s    = 1'b0;
        narrow_s = r_r[OUT_W-1:0];
    end
`endif

    // Output stage and sticky overflow (run low wins over a simultaneous set).
    always_ff @(posedge clock) begin
        if (reset) begin
            dump_strobe <= 1'b0;
            dump_out    <= '0;
            overflow    <= 1'b0;
        end else begin
            dump_strobe <= v2_r;
            if (v2_r) begin
                dump_out <= narrow_s;
            end
            if (!run) begin
                overflow <= 1'b0;
            end else if (v2_r & sat_s) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acc_dump_scale.sv
// Directed bench for acc_dump_scale with a behavioural accumulator in the loop.
module tb_acc_dump_scale;

    logic                clock;
    logic                reset;
    logic                run;
    logic [15:0]         length;
    logic [5:0]          shift;
    logic                stb_in;
    logic                acc_valid;
    logic signed [49:0]  acc_sum;
    logic signed [49:0]  addend;
    logic                clear_out;
    logic                dump_strobe;
    logic signed [15:0]  dump_out;
    logic                overflow;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s0;
    logic signed [15:0] dq[$];
    int                 dc[$];

    acc_dump_scale dut (
        .clock(clock), .reset(reset), .run(run), .length(length), .shift(shift),
        .stb_in(stb_in), .acc_valid(acc_valid), .sum_in(acc_sum),
        .clear_out(clear_out), .dump_strobe(dump_strobe), .dump_out(dump_out),
        .overflow(overflow), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Accumulator model: loads addend on clear, else adds; enable_out is enable_in delayed.
    always @(posedge clock) begin
        if (reset) begin
            acc_valid <= 1'b0;
            acc_sum   <= '0;
        end else begin
            acc_valid <= stb_in;
            if (stb_in) acc_sum <= clear_out ? addend : acc_sum + addend;
        end
    end

    // Dump monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (dump_strobe === 1'b1) begin
            dq.push_back(dump_out);
            dc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; length = 16'd4; shift = 6'd0; stb_in = 1'b0; addend = '0;
        ticks(2);
        chk("rst_strobe", dump_strobe, 1'b0);
        chk("rst_out", dump_out, 64'sd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Reset mid-period
        reset = 1'b0; run = 1'b1; addend = 50'sd100;
        stb_in = 1'b1; #1;
        chk("t1_clr0", clear_out, 1'b1);
        tick();
        chk("t1_clr1", clear_out, 1'b0);
        chk("t1_busy", busy, 1'b1);
        tick();
        stb_in = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("t1_strobe", dump_strobe, 1'b0);
        chk("t1_busy_rst", busy, 1'b0);
        ticks(6);
        chk("t1_nodump", dq.size(), 64'sd0);

        // Basic period, len=4, continuous strobes
        dq.delete(); dc.delete();
        for (int i = 0; i < 12; i++) begin
            stb_in = 1'b1; #1;
            chk("t2_clr", clear_out, (i % 4) == 0);
            if (i == 0) s0 = cyc;
            tick();
        end
        stb_in = 1'b0;
        ticks(8);
        chk("t2_count", dq.size(), 64'sd3);
        for (int k = 0; k < dq.size(); k++) begin
            chk("t2_val", dq[k], 64'sd400);
            chk("t2_lat", dc[k], s0 + 4 * k + 7);
        end
        chk("t2_idle", busy, 1'b0);

        // Rounding, len=1 shift=2
        dq.delete(); dc.delete();
        length = 16'd1; shift = 6'd2;
        stb_in = 1'b1; addend = 50'sd6; tick();
        addend = -50'sd6; tick();
        addend = 50'sd5; tick();
        stb_in = 1'b0;
        ticks(6);
        chk("t3_count", dq.size(), 64'sd3);
        if (dq.size() == 3) begin
            chk("t3_pos6", dq[0], 64'sd2);
            chk("t3_neg6", dq[1], -64'sd1);
            chk("t3_pos5", dq[2], 64'sd1);
            chk("t3_tput", dc[2] - dc[0], 64'sd2);
        end

        // Large totals, shift=0
        dq.delete(); dc.delete();
        shift = 6'd0; addend = 50'sh100_0000_0000;
        stb_in = 1'b1; tick(); stb_in = 1'b0;
        ticks(6);
        chk("t4_count", dq.size(), 64'sd1);
`ifdef DUMP_SATURATE_EN
        chk("t4_satpos", dq[0], 64'sd32767);
        chk("t4_ovf", overflow, 1'b1);
        ticks(3);
        chk("t4_ovf_hold", overflow, 1'b1);
`else
        chk("t4_wrappos", dq[0], 64'sd0);
        chk("t4_ovf", overflow, 1'b0);
`endif
        addend = -50'sh100_0000_0000;
        stb_in = 1'b1; tick(); stb_in = 1'b0;
        ticks(6);
        chk("t4_count2", dq.size(), 64'sd2);
`ifdef DUMP_SATURATE_EN
        chk("t4_satneg", dq[1], -64'sd32768);
`else
        chk("t4_wrapneg", dq[1], 64'sd0);
`endif
        run = 1'b0; tick();
        chk("t4_ovf_clr", overflow, 1'b0);

        // Abort mid-period, then a full period of 8
        dq.delete(); dc.delete();
        run = 1'b1; length = 16'd8; addend = 50'sd1;
        for (int i = 0; i < 5; i++) begin
            stb_in = 1'b1; #1;
            if (i == 0) chk("t5_clr_first", clear_out, 1'b1);
            tick();
        end
        stb_in = 1'b0; run = 1'b0; tick();
        ticks(8);
        chk("t5_nodump", dq.size(), 64'sd0);
        chk("t5_busy", busy, 1'b0);
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stb_in = 1'b1; #1;
            chk("t5_clr", clear_out, i == 0);
            tick();
        end
        stb_in = 1'b0;
        ticks(6);
        chk("t5_count", dq.size(), 64'sd1);
        if (dq.size() == 1) chk("t5_val", dq[0], 64'sd8);

        // length=0 behaves as 1
        dq.delete(); dc.delete();
        length = 16'd0; addend = 50'sd3;
        for (int i = 0; i < 4; i++) begin
            stb_in = 1'b1; #1;
            chk("t5_len0_clr", clear_out, 1'b1);
            tick();
        end
        stb_in = 1'b0;
        ticks(6);
        chk("t5_len0_count", dq.size(), 64'sd4);
        for (int k = 0; k < dq.size(); k++) chk("t5_len0_val", dq[k], 64'sd3);

        // Gapped strobes, length changed mid-period
        dq.delete(); dc.delete();
        length = 16'd3; addend = 50'sd10;
        for (int s = 0; s < 8; s++) begin
            stb_in = 1'b1; #1;
            chk("t6_clr", clear_out, (s == 0) || (s == 3));
            tick();
            stb_in = 1'b0;
            if (s == 1) length = 16'd5;
            ticks(2);
        end
        ticks(6);
        chk("t6_count", dq.size(), 64'sd2);
        if (dq.size() == 2) begin
            chk("t6_first", dq[0], 64'sd30);
            chk("t6_second", dq[1], 64'sd50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
